// File: rtl/l1_cache_assoc.sv
// l1_cache_assoc: read-only, N-way set-associative L1 cache with true-LRU
// replacement, whole-line refill on miss and single-cycle flush.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   req_valid/req_ready  word read request handshake, req_addr = word address
//   flush                level; invalidates every line when seen in IDLE
//   rsp_valid/rsp_data   one-cycle response pulse with the requested word
//   mem_req/mem_addr     line fill request, held until mem_valid
//   mem_valid/mem_line   fill line delivery, word 0 in the LSBs
//   hit_cnt/miss_cnt     saturating access counters (only with L1_PERF_CNT_EN)
//
// Build option: define L1_PERF_CNT_EN to add the hit_cnt/miss_cnt outputs.
module l1_cache_assoc #(
  parameter int unsigned ADDR_W     = 30,
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned SETS       = 8,
  parameter int unsigned WAYS       = 2,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        req_valid,
  input  logic [ADDR_W-1:0]                           req_addr,
  output logic                                        req_ready,
  input  logic                                        flush,
  output logic                                        rsp_valid,
  output logic [WORD_W-1:0]                           rsp_data,
  output logic                                        mem_req,
  output logic [ADDR_W-$clog2(LINE_WORDS)-1:0]        mem_addr,
  input  logic                                        mem_valid,
  input  logic [LINE_WORDS*WORD_W-1:0]                mem_line
`ifdef L1_PERF_CNT_EN
  ,
  output logic [31:0]                                 hit_cnt,
  output logic [31:0]                                 miss_cnt
`endif
);

  localparam int unsigned OFF    = $clog2(LINE_WORDS);
  localparam int unsigned IDX    = $clog2(SETS);
  localparam int unsigned TAG_W  = ADDR_W - OFF - IDX;
  localparam int unsigned LINE_W = LINE_WORDS * WORD_W;
  localparam int unsigned AGE_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned WAY_W  = AGE_W;

  typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;

  state_t state, state_nxt;

  // Storage: data/tag arrays are never reset, valid/age arrays are.
  logic [LINE_W-1:0] data_arr  [SETS][WAYS];
  logic [TAG_W-1:0]  tag_arr   [SETS][WAYS];
  logic [WAYS-1:0]   valid_arr [SETS];
  logic [AGE_W-1:0]  age_arr   [SETS][WAYS];

  logic [ADDR_W-1:0] addr_q;

  // Request-side address fields
  logic [IDX-1:0]   req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [OFF-1:0]   req_off;
  assign req_idx = req_addr[OFF +: IDX];
  assign req_tag = req_addr[ADDR_W-1 -: TAG_W];
  assign req_off = req_addr[OFF-1:0];

  // Fill-side address fields, from the latched miss address
  logic [IDX-1:0]   fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic [OFF-1:0]   fill_off;
  assign fill_idx = addr_q[OFF +: IDX];
  assign fill_tag = addr_q[ADDR_W-1 -: TAG_W];
  assign fill_off = addr_q[OFF-1:0];

  assign mem_addr = addr_q[ADDR_W-1:OFF];

  function automatic logic [WORD_W-1:0] sel_word(input logic [LINE_W-1:0] line,
                                                 input logic [OFF-1:0]    off);
    return line[int'(off) * int'(WORD_W) +: WORD_W];
  endfunction

  // Tag lookup
  logic             hit;
  logic [WAY_W-1:0] hit_way;
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (valid_arr[req_idx][w] && (tag_arr[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Victim: lowest invalid way, otherwise the oldest way
  logic [WAY_W-1:0] victim;
  logic             found_inv;
  always_comb begin
    victim    = '0;
    found_inv = 1'b0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (!valid_arr[fill_idx][w] && !found_inv) begin
        victim    = WAY_W'(w);
        found_inv = 1'b1;
      end
    end
    if (!found_inv) begin
      for (int w = 0; w < int'(WAYS); w++) begin
        if (age_arr[fill_idx][w] == AGE_W'(WAYS - 1)) victim = WAY_W'(w);
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid && !flush && !hit) state_nxt = FILL;
      FILL:    if (mem_valid) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs and datapath enables
  logic hit_upd, miss_acc, fill_we;
  always_comb begin
    req_ready = 1'b0;
    mem_req   = 1'b0;
    hit_upd   = 1'b0;
    miss_acc  = 1'b0;
    fill_we   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !flush && !rst;
        hit_upd   = req_valid && req_ready && hit;
        miss_acc  = req_valid && req_ready && !hit;
      end
      FILL: begin
        mem_req = !rst;
        fill_we = mem_valid;
      end
      default: ;
    endcase
  end

  // LRU: ways younger than the touched way age by one, touched way becomes 0
  logic             upd_en;
  logic [IDX-1:0]   upd_set;
  logic [WAY_W-1:0] upd_way;
  logic [AGE_W-1:0] age_nxt [WAYS];
  always_comb begin
    upd_en  = hit_upd || fill_we;
    upd_set = fill_we ? fill_idx : req_idx;
    upd_way = fill_we ? victim : hit_way;
    for (int w = 0; w < int'(WAYS); w++) begin
      age_nxt[w] = age_arr[upd_set][w];
      if (age_arr[upd_set][w] < age_arr[upd_set][upd_way])
        age_nxt[w] = age_arr[upd_set][w] + AGE_W'(1);
    end
    age_nxt[upd_way] = '0;
  end

  // Control state: valid bits, ages, miss address, response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < int'(SETS); s++) begin
        valid_arr[s] <= '0;
        for (int w = 0; w < int'(WAYS); w++) age_arr[s][w] <= AGE_W'(w);
      end
      addr_q    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= hit_upd || fill_we;
      if (hit_upd)  rsp_data <= sel_word(data_arr[req_idx][hit_way], req_off);
      if (fill_we)  rsp_data <= sel_word(mem_line, fill_off);
      if (miss_acc) addr_q <= req_addr;
      if (upd_en) begin
        for (int w = 0; w < int'(WAYS); w++) age_arr[upd_set][w] <= age_nxt[w];
      end
      if (fill_we) valid_arr[fill_idx][victim] <= 1'b1;
      if ((state == IDLE) && flush) begin
        for (int s = 0; s < int'(SETS); s++) valid_arr[s] <= '0;
      end
    end
  end

  // Line data and tag write on fill
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_arr[fill_idx][victim] <= mem_line;
      tag_arr[fill_idx][victim]  <= fill_tag;
    end
  end

`ifdef L1_PERF_CNT_EN
  // Saturating access counters; flush leaves them alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit_upd && (hit_cnt != '1))   hit_cnt  <= hit_cnt + 32'd1;
      if (miss_acc && (miss_cnt != '1)) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/l1_cache_assoc.md
Name: l1_cache_assoc

Overview:
Parametrised, read-only, N-way set-associative L1 cache, the successor to the fixed 8-set, 2-way, 4-word-line L1.
- Sits between a pipeline fetch/load stage and the main-memory line interface.
- Serves one word per request over a valid/ready handshake.
- Refills whole lines from memory on a miss, with true-LRU replacement and a single-cycle flush.

Parameters:
ADDR_W, 30, word-address width (byte bits already stripped)
WORD_W, 32, data word width
SETS, 8, number of sets; power of two, >=2
WAYS, 2, associativity; power of two, >=1
LINE_WORDS, 4, words per line; power of two, >=2

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
req_valid  in  1  read request valid
req_addr  in  ADDR_W  word address: [OFF-1:0] word offset, [OFF+IDX-1:OFF] set index, remainder tag (OFF=log2 LINE_WORDS, IDX=log2 SETS)
req_ready  out  1  request accepted when req_valid && req_ready
flush  in  1  invalidate all lines
rsp_valid  out  1  one-cycle pulse, rsp_data valid
rsp_data  out  WORD_W  requested word
mem_req  out  1  line fill request, held until mem_valid
mem_addr  out  ADDR_W-OFF  line address = req_addr[ADDR_W-1:OFF]
mem_valid  in  1  fill line delivered (one-cycle pulse)
mem_line  in  LINE_WORDS*WORD_W  fill data, word 0 in LSBs

Behaviour:
- Reset (async, any state):
  - State goes to IDLE; all valid bits clear.
  - LRU ages per set reset to age[w]=w.
  - rsp_valid, mem_req and req_ready (combinational) are 0 while rst is high.
  - rsp_data resets to 0.
  - Data/tag arrays are not cleared.
- FSM states: IDLE, FILL, RESP.
- req_ready = (state==IDLE) && !flush && !rst.
- IDLE:
  - flush high: all valid bits clear at the next edge; req_valid is ignored that cycle.
  - Request accepted and hit: rsp_data <= matching word, rsp_valid=1 the next cycle (latency 1), LRU updated, stay in IDLE. Back-to-back hits sustain 1 per cycle.
  - Request accepted and miss: latch addr; go to FILL; mem_req=1 from the next cycle.
- FILL:
  - mem_req=1 and mem_addr are stable until mem_valid.
  - On mem_valid:
    - Victim way = lowest-index invalid way in the set, else the way with age==WAYS-1.
    - Write mem_line, the tag and valid=1 into the victim way.
    - Update LRU; capture the requested word into rsp_data; go to RESP.
  - mem_req drops the cycle after mem_valid.
  - flush in FILL is ignored (it is a level; the requester holds it until req_ready rises).
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. Miss latency = 1 cycle after mem_valid.
- mem_valid outside FILL is ignored: no state or array change.
- LRU (true LRU, log2(WAYS)-bit age per way per set):
  - On hit or fill to way k: ways whose age < age[k] increment, then age[k]=0.
  - WAYS=1: no ages, victim is always way 0.
- Hit match: valid && tag equal. Multiple matches cannot occur, because a fill only targets a missing tag.
- No response backpressure: the consumer must take rsp_valid when it is pulsed.
- Reset mid-FILL: mem_req drops immediately; a late mem_valid is ignored.

Optional Feature:
Macro L1_PERF_CNT_EN.
- Defined:
  - Adds outputs hit_cnt and miss_cnt, each 32 bits, cleared on rst.
  - hit_cnt increments on each accepted hit; miss_cnt increments on each accepted miss.
  - Both saturate at 0xFFFFFFFF; flush does not clear them.
- Undefined: the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Defaults; reset; read 0x010 -> miss, mem_req next cycle with mem_addr=0x004; deliver line {W3..W0}={0xD3,0xD2,0xD1,0xD0} -> rsp_valid 1 cycle later, rsp_data=0xD0, mem_req low.
- Then reads 0x011 and 0x013 back-to-back -> two hits, rsp_data 0xD1 then 0xD3 on consecutive cycles, mem_req never asserted.
- Set-0 conflict, WAYS=2:
  - Fill A=0x000 and B=0x020, read A, read C=0x040 -> C evicts B.
  - Read A -> hit; read B -> miss with mem_addr=0x008.
- flush for 1 cycle in IDLE with a concurrent req_valid -> request not accepted (req_ready=0); re-read 0x010 -> miss.
- mem_valid pulsed in IDLE -> no rsp_valid, no array change. rst raised during FILL -> mem_req=0 immediately; the following mem_valid is ignored; read 0x010 misses again.
- L1_PERF_CNT_EN defined, the first three scenarios run -> hit_cnt=4, miss_cnt=5; after flush the counts are unchanged.
